// File: rtl/farm_act_pkg.sv
// Shared encodings for the irrigation actuator sequencer: state codes, fault codes, field widths.
package farm_act_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned FC_W      = 2;
  localparam int unsigned CYC_CNT_W = 8;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] VALVE_OPEN = 3'd1;
  localparam logic [2:0] PUMPING    = 3'd2;
  localparam logic [2:0] PUMP_STOP  = 3'd3;
  localparam logic [2:0] COOLDOWN   = 3'd4;
  localparam logic [2:0] FAULT      = 3'd5;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_DRY   = 2'b01;
  localparam logic [1:0] FC_ESTOP = 2'b10;

endpackage

// File: rtl/irrigation_actuator_sequencer_if.sv
// Request/sensor inputs and actuator/status outputs of the irrigation actuator sequencer.
interface irrigation_actuator_sequencer_if;
  import farm_act_pkg::*;

  logic                 ena;
  logic                 irrigate_req;
  logic                 flow_ok;
  logic                 estop;
  logic                 fault_clr;
  logic                 valve_drive;
  logic                 pump_drive;
  logic                 busy;
  logic                 fault;
  logic [FC_W-1:0]      fault_code;
  logic                 run_limit_hit;
  logic [STATE_W-1:0]   state_o;
  logic [CYC_CNT_W-1:0] cycle_count;

  modport master (
    output ena, irrigate_req, flow_ok, estop, fault_clr,
    input  valve_drive, pump_drive, busy, fault, fault_code,
           run_limit_hit, state_o, cycle_count
  );

  modport slave (
    input  ena, irrigate_req, flow_ok, estop, fault_clr,
    output valve_drive, pump_drive, busy, fault, fault_code,
           run_limit_hit, state_o, cycle_count
  );

endinterface

// File: rtl/irrigation_actuator_sequencer_seq_timer.sv
// Loadable saturating up/down counter with zero flag; used as the sequencer state timer.
module seq_timer #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_step,
  input  logic         i_up,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load wins over stepping; stepping saturates at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      if (i_load) begin
        r_count <= i_load_val;
      end else if (i_step) begin
        if (i_up) begin
          if (r_count != '1) r_count <= r_count + W'(1);
        end else begin
          if (r_count != '0) r_count <= r_count - W'(1);
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/irrigation_actuator_sequencer.sv
// Valve/pump sequencer: safe open/close ordering, run limit, cooldown, dry-run and estop faults.
module irrigation_actuator_sequencer
  import farm_act_pkg::*;
#(
  parameter int unsigned SETTLE_CYC   = 16,
  parameter int unsigned RUNDOWN_CYC  = 16,
  parameter int unsigned MAX_RUN_CYC  = 4000,
  parameter int unsigned COOLDOWN_CYC = 64,
  parameter int unsigned FLOW_TIMEOUT = 32,
  parameter int unsigned CNT_W        = 12
) (
  input logic clk,
  input logic rst,
  irrigation_actuator_sequencer_if.slave bus
);

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [FC_W-1:0]      r_fault_code;
  logic [FC_W-1:0]      w_code_nxt;
  logic                 r_run_limit_hit;
  logic                 w_rlh_nxt;
  logic [CYC_CNT_W-1:0] r_cycle_count;
  logic                 w_cyc_inc;
  logic [CNT_W-1:0]     r_flow_cnt;
  logic [CNT_W-1:0]     w_flow_nxt;

  logic                 w_tmr_load;
  logic [CNT_W-1:0]     w_tmr_val;
  logic                 w_tmr_step;
  logic                 w_tmr_up;
  logic [CNT_W-1:0]     w_tmr_count;
  logic                 w_tmr_zero;

  seq_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_en       (bus.ena),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_step     (w_tmr_step),
    .i_up       (w_tmr_up),
    .o_count    (w_tmr_count),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_state <= IDLE;
    else if (bus.ena) r_state <= w_state_nxt;
  end

  // Next state, timer control and registered-output updates; estop overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_fault_code;
    w_rlh_nxt   = 1'b0;
    w_cyc_inc   = 1'b0;
    w_flow_nxt  = r_flow_cnt;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_tmr_step  = 1'b0;
    w_tmr_up    = 1'b0;

    if (bus.estop) begin
      w_state_nxt = FAULT;
      w_code_nxt  = FC_ESTOP;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.irrigate_req) begin
            w_state_nxt = VALVE_OPEN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = CNT_W'(SETTLE_CYC - 1);
          end
        end
        VALVE_OPEN: begin
          if (!bus.irrigate_req) begin
            w_state_nxt = PUMP_STOP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = CNT_W'(RUNDOWN_CYC - 1);
          end else if (w_tmr_zero) begin
            w_state_nxt = PUMPING;
            w_tmr_load  = 1'b1;
            w_flow_nxt  = '0;
          end else begin
            w_tmr_step  = 1'b1;
          end
        end
        PUMPING: begin
          w_flow_nxt = bus.flow_ok ? '0 : r_flow_cnt + CNT_W'(1);
          if (!bus.flow_ok && (r_flow_cnt == CNT_W'(FLOW_TIMEOUT - 1))) begin
            w_state_nxt = FAULT;
            w_code_nxt  = FC_DRY;
          end else if ((w_tmr_count == CNT_W'(MAX_RUN_CYC - 1)) || !bus.irrigate_req) begin
            w_state_nxt = PUMP_STOP;
            w_tmr_load  = 1'b1;
            w_tmr_val   = CNT_W'(RUNDOWN_CYC - 1);
            w_cyc_inc   = 1'b1;
            w_rlh_nxt   = (w_tmr_count == CNT_W'(MAX_RUN_CYC - 1));
          end else begin
            w_tmr_step  = 1'b1;
            w_tmr_up    = 1'b1;
          end
        end
        PUMP_STOP: begin
          if (w_tmr_zero) begin
            w_state_nxt = COOLDOWN;
            w_tmr_load  = 1'b1;
            w_tmr_val   = CNT_W'(COOLDOWN_CYC - 1);
          end else begin
            w_tmr_step  = 1'b1;
          end
        end
        COOLDOWN: begin
          if (w_tmr_zero) w_state_nxt = IDLE;
          else            w_tmr_step  = 1'b1;
        end
        FAULT: begin
          if (bus.fault_clr && !bus.irrigate_req) begin
            w_state_nxt = COOLDOWN;
            w_code_nxt  = FC_NONE;
            w_tmr_load  = 1'b1;
            w_tmr_val   = CNT_W'(COOLDOWN_CYC - 1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_code    <= FC_NONE;
      r_run_limit_hit <= 1'b0;
      r_cycle_count   <= '0;
      r_flow_cnt      <= '0;
    end else if (bus.ena) begin
      r_fault_code    <= w_code_nxt;
      r_run_limit_hit <= w_rlh_nxt;
      r_flow_cnt      <= w_flow_nxt;
      if (w_cyc_inc) r_cycle_count <= r_cycle_count + CYC_CNT_W'(1);
    end
  end

  // Drives decode straight from the state register so reset drops them without a clock edge.
  assign bus.valve_drive   = (r_state == VALVE_OPEN) || (r_state == PUMPING) || (r_state == PUMP_STOP);
  assign bus.pump_drive    = (r_state == PUMPING);
  assign bus.busy          = (r_state != IDLE) && (r_state != FAULT);
  assign bus.fault         = (r_state == FAULT);
  assign bus.fault_code    = r_fault_code;
  assign bus.run_limit_hit = r_run_limit_hit;
  assign bus.state_o       = r_state;
  assign bus.cycle_count   = r_cycle_count;

endmodule

// File: tb/tb_irrigation_actuator_sequencer.sv
// Scoreboard bench: stimulus queues expected output snapshots with cycle gaps, monitor checks each output change.
module tb_irrigation_actuator_sequencer;
  import farm_act_pkg::*;

  typedef struct {
    int          dt;
    logic [17:0] snap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   ev_idx = 0;
  int   last_cyc = 0;
  bit   mon_en = 1'b0;
  bit   mon_started = 1'b0;
  logic [17:0] last_obs = '0;
  logic [17:0] obs;
  exp_t e;
  exp_t q[$];

  irrigation_actuator_sequencer_if bus();

  irrigation_actuator_sequencer #(
    .SETTLE_CYC   (4),
    .RUNDOWN_CYC  (3),
    .MAX_RUN_CYC  (10),
    .COOLDOWN_CYC (5),
    .FLOW_TIMEOUT (3),
    .CNT_W        (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] mk(input logic [2:0] st, input logic [1:0] code,
                                     input logic rlh, input logic [7:0] cc);
    logic v, p, b, f;
    case (st)
      VALVE_OPEN: begin v = 1'b1; p = 1'b0; end
      PUMPING:    begin v = 1'b1; p = 1'b1; end
      PUMP_STOP:  begin v = 1'b1; p = 1'b0; end
      default:    begin v = 1'b0; p = 1'b0; end
    endcase
    b = (st != IDLE) && (st != FAULT);
    f = (st == FAULT);
    return {v, p, b, f, code, rlh, st, cc};
  endfunction

  task automatic push(input int dt, input logic [2:0] st, input logic [1:0] code,
                      input logic rlh, input logic [7:0] cc);
    exp_t x;
    x.dt   = dt;
    x.snap = mk(st, code, rlh, cc);
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the observed outputs is one event checked against the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      obs = {bus.valve_drive, bus.pump_drive, bus.busy, bus.fault, bus.fault_code,
             bus.run_limit_hit, bus.state_o, bus.cycle_count};
      if (!mon_started || obs != last_obs) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event idx=%0d got=%h cyc=%0d", ev_idx, obs, cyc);
        end else begin
          e = q.pop_front();
          if (obs != e.snap || (e.dt >= 0 && (cyc - last_cyc) != e.dt)) begin
            failures++;
            $display("FAIL event_%0d got snap=%h dt=%0d want snap=%h dt=%0d",
                     ev_idx, obs, cyc - last_cyc, e.snap, e.dt);
          end
        end
        ev_idx++;
        last_obs    = obs;
        last_cyc    = cyc;
        mon_started = 1'b1;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b1; bus.irrigate_req = 1'b0; bus.flow_ok = 1'b1;
    bus.estop = 1'b0; bus.fault_clr = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    push(-1, IDLE, FC_NONE, 1'b0, 8'd0);
    mon_en = 1'b1;
    wait_cyc(3);

    // Normal cycle, with a stray fault_clr during pumping
    push(-1, VALVE_OPEN, FC_NONE, 1'b0, 8'd0);
    push(4,  PUMPING,    FC_NONE, 1'b0, 8'd0);
    push(6,  PUMP_STOP,  FC_NONE, 1'b0, 8'd1);
    push(3,  COOLDOWN,   FC_NONE, 1'b0, 8'd1);
    push(5,  IDLE,       FC_NONE, 1'b0, 8'd1);
    bus.irrigate_req = 1'b1;
    wait_cyc(7);  bus.fault_clr = 1'b1;
    wait_cyc(1);  bus.fault_clr = 1'b0;
    wait_cyc(2);  bus.irrigate_req = 1'b0;
    wait_cyc(14);

    // Run limit, re-entry after cooldown, then request drop during VALVE_OPEN
    push(-1, VALVE_OPEN, FC_NONE, 1'b0, 8'd1);
    push(4,  PUMPING,    FC_NONE, 1'b0, 8'd1);
    push(10, PUMP_STOP,  FC_NONE, 1'b1, 8'd2);
    push(1,  PUMP_STOP,  FC_NONE, 1'b0, 8'd2);
    push(2,  COOLDOWN,   FC_NONE, 1'b0, 8'd2);
    push(5,  IDLE,       FC_NONE, 1'b0, 8'd2);
    push(1,  VALVE_OPEN, FC_NONE, 1'b0, 8'd2);
    push(1,  PUMP_STOP,  FC_NONE, 1'b0, 8'd2);
    push(3,  COOLDOWN,   FC_NONE, 1'b0, 8'd2);
    push(5,  IDLE,       FC_NONE, 1'b0, 8'd2);
    bus.irrigate_req = 1'b1;
    wait_cyc(24); bus.irrigate_req = 1'b0;
    wait_cyc(14);

    // Dry run; clear ignored while request high, accepted once low
    push(-1, VALVE_OPEN, FC_NONE, 1'b0, 8'd2);
    push(4,  PUMPING,    FC_NONE, 1'b0, 8'd2);
    push(3,  FAULT,      FC_DRY,  1'b0, 8'd2);
    push(7,  COOLDOWN,   FC_NONE, 1'b0, 8'd2);
    push(5,  IDLE,       FC_NONE, 1'b0, 8'd2);
    bus.irrigate_req = 1'b1; bus.flow_ok = 1'b0;
    wait_cyc(10); bus.fault_clr = 1'b1;
    wait_cyc(1);  bus.fault_clr = 1'b0;
    wait_cyc(1);  bus.irrigate_req = 1'b0;
    wait_cyc(2);  bus.fault_clr = 1'b1;
    wait_cyc(1);  bus.fault_clr = 1'b0; bus.flow_ok = 1'b1;
    wait_cyc(10);

    // Estop together with request drop while pumping: no rundown
    push(-1, VALVE_OPEN, FC_NONE,  1'b0, 8'd2);
    push(4,  PUMPING,    FC_NONE,  1'b0, 8'd2);
    push(3,  FAULT,      FC_ESTOP, 1'b0, 8'd2);
    push(3,  COOLDOWN,   FC_NONE,  1'b0, 8'd2);
    push(5,  IDLE,       FC_NONE,  1'b0, 8'd2);
    bus.irrigate_req = 1'b1;
    wait_cyc(7);  bus.estop = 1'b1; bus.irrigate_req = 1'b0;
    wait_cyc(1);  bus.estop = 1'b0;
    wait_cyc(2);  bus.fault_clr = 1'b1;
    wait_cyc(1);  bus.fault_clr = 1'b0;
    wait_cyc(10);

    // Estop while latched in a dry-run fault overwrites the code
    push(-1, VALVE_OPEN, FC_NONE,  1'b0, 8'd2);
    push(4,  PUMPING,    FC_NONE,  1'b0, 8'd2);
    push(3,  FAULT,      FC_DRY,   1'b0, 8'd2);
    push(2,  FAULT,      FC_ESTOP, 1'b0, 8'd2);
    push(2,  COOLDOWN,   FC_NONE,  1'b0, 8'd2);
    push(5,  IDLE,       FC_NONE,  1'b0, 8'd2);
    bus.irrigate_req = 1'b1; bus.flow_ok = 1'b0;
    wait_cyc(9);  bus.estop = 1'b1;
    wait_cyc(1);  bus.estop = 1'b0; bus.irrigate_req = 1'b0; bus.flow_ok = 1'b1;
    wait_cyc(1);  bus.fault_clr = 1'b1;
    wait_cyc(1);  bus.fault_clr = 1'b0;
    wait_cyc(10);

    // Cooldown lockout: request re-raised during cooldown waits for IDLE
    push(-1, VALVE_OPEN, FC_NONE, 1'b0, 8'd2);
    push(4,  PUMPING,    FC_NONE, 1'b0, 8'd2);
    push(2,  PUMP_STOP,  FC_NONE, 1'b0, 8'd3);
    push(3,  COOLDOWN,   FC_NONE, 1'b0, 8'd3);
    push(5,  IDLE,       FC_NONE, 1'b0, 8'd3);
    push(1,  VALVE_OPEN, FC_NONE, 1'b0, 8'd3);
    push(1,  PUMP_STOP,  FC_NONE, 1'b0, 8'd3);
    push(3,  COOLDOWN,   FC_NONE, 1'b0, 8'd3);
    push(5,  IDLE,       FC_NONE, 1'b0, 8'd3);
    bus.irrigate_req = 1'b1;
    wait_cyc(6);  bus.irrigate_req = 1'b0;
    wait_cyc(4);  bus.irrigate_req = 1'b1;
    wait_cyc(6);  bus.irrigate_req = 1'b0;
    wait_cyc(12);

    // Clock-enable freeze in VALVE_OPEN, then asynchronous reset while pumping
    push(-1, VALVE_OPEN, FC_NONE, 1'b0, 8'd3);
    push(11, PUMPING,    FC_NONE, 1'b0, 8'd3);
    push(2,  IDLE,       FC_NONE, 1'b0, 8'd0);
    bus.irrigate_req = 1'b1;
    wait_cyc(2);  bus.ena = 1'b0;
    wait_cyc(7);  bus.ena = 1'b1;
    wait_cyc(5);
    #1;
    rst = 1'b1; bus.irrigate_req = 1'b0;
    wait_cyc(1);  rst = 1'b0;
    wait_cyc(6);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irrigation_actuator_sequencer.md
Name: irrigation_actuator_sequencer

Overview:
Downstream stage of the sensor/ML status core. It consumes the core's irrigation request and drives the physical valve and pump. It enforces safe ordering: valve opens before the pump starts, and the pump stops before the valve closes. It also enforces a maximum run time, a minimum off time, dry-run detection and emergency stop, and reports a latched fault code and a completed-cycle count for the status/debug pins.

Parameters:
SETTLE_CYC, 16, cycles the valve is open before the pump starts (>=1)
RUNDOWN_CYC, 16, cycles the valve stays open after the pump stops (>=1)
MAX_RUN_CYC, 4000, maximum pumping cycles per request (>=1)
COOLDOWN_CYC, 64, minimum all-off cycles before a new request is accepted (>=1)
FLOW_TIMEOUT, 32, consecutive pumping cycles with flow_ok=0 that declare a dry run (>=1)
CNT_W, 12, timer width; must hold the largest of the above

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
ena  in  1  clock enable; when low, all state, timers and outputs hold
irrigate_req  in  1  level request from the status core (pump command)
flow_ok  in  1  flow sensor; 1 = water flowing
estop  in  1  emergency stop; synchronous, highest priority
fault_clr  in  1  clears a latched fault
valve_drive  out  1  valve actuator
pump_drive  out  1  pump actuator
busy  out  1  1 in any state except IDLE and FAULT
fault  out  1  1 in FAULT
fault_code  out  2  00 none, 01 dry-run, 10 estop, 11 reserved
run_limit_hit  out  1  one-cycle pulse when MAX_RUN_CYC forces a stop
state_o  out  3  current state encoding
cycle_count  out  8  completed pumping cycles; wraps 255->0

Behaviour:
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- On rst: state IDLE, timer 0, flow counter 0, valve_drive=0, pump_drive=0, busy=0, fault=0, fault_code=00, run_limit_hit=0, cycle_count=0. Asserting rst mid-operation drops both drives immediately, with no rundown.
- Every transition below is qualified by ena=1.
- State encoding: IDLE=0, VALVE_OPEN=1, PUMPING=2, PUMP_STOP=3, COOLDOWN=4, FAULT=5.
- Drive outputs per state:
  - IDLE: valve 0, pump 0
  - VALVE_OPEN: valve 1, pump 0
  - PUMPING: valve 1, pump 1
  - PUMP_STOP: valve 1, pump 0
  - COOLDOWN: valve 0, pump 0
  - FAULT: valve 0, pump 0
- IDLE: irrigate_req=1 -> VALVE_OPEN, timer loads SETTLE_CYC-1.
- VALVE_OPEN:
  - Timer decrements each cycle; at 0 -> PUMPING, timer loads 0, flow counter loads 0.
  - The valve is high for exactly SETTLE_CYC cycles before the pump rises.
  - Request drop here -> PUMP_STOP (valve rundown still applies).
- PUMPING:
  - Run timer increments each cycle.
  - Flow counter increments when flow_ok=0 and clears when flow_ok=1.
  - Priority order:
    - flow counter reaches FLOW_TIMEOUT -> FAULT, code 01.
    - run timer reaches MAX_RUN_CYC-1 -> PUMP_STOP, run_limit_hit pulses on the transition cycle.
    - irrigate_req=0 -> PUMP_STOP.
  - Pump is high for at most MAX_RUN_CYC cycles.
  - Every entry to PUMP_STOP from PUMPING increments cycle_count.
- PUMP_STOP: timer loads RUNDOWN_CYC-1 on entry, counts to 0 -> COOLDOWN, timer loads COOLDOWN_CYC-1.
- COOLDOWN: irrigate_req is ignored; timer at 0 -> IDLE. A request still high at that point re-enters VALVE_OPEN on the next cycle.
- FAULT:
  - Latched; fault_code holds its value.
  - Exit to COOLDOWN only when fault_clr=1 and irrigate_req=0 in the same cycle. On exit, fault_code returns to 00.
  - fault_clr with the request high is ignored.
- estop=1 in any state (including FAULT) -> FAULT, code 10, on the next edge. estop beats every other event in the same cycle. A dry-run code is overwritten by estop.
- fault_clr outside FAULT has no effect.
- Timers never underflow or overflow; compare-then-load only.

Decomposition:
- Shared package farm_act_pkg holds the state encoding localparams (IDLE..FAULT) and fault code constants (FC_NONE, FC_DRY, FC_ESTOP).
- One natural sub-module: seq_timer, a CNT_W-bit loadable down/up counter with load, enable and zero flag. It is instantiated once for the state timer.
- The flow counter stays inline.

Test Plan:
Bench parameters: SETTLE=4, RUNDOWN=3, MAX_RUN=10, COOLDOWN=5, FLOW_TIMEOUT=3.
- Normal cycle: req high at t0 with flow_ok=1, dropped after pump on for 6 cycles -> valve rises t0+1, pump rises t0+5, pump falls 6 cycles later, valve falls 3 cycles after that, busy low 5 cycles later, cycle_count=1.
- Run limit: req held high with flow_ok=1 -> pump high exactly 10 cycles, run_limit_hit single pulse, state 3, cycle_count=1; req still high re-enters VALVE_OPEN after cooldown.
- Dry run: flow_ok=0 from pump start -> FAULT after 3 pumping cycles, both drives 0, fault_code=01, cycle_count unchanged; fault_clr with req=1 ignored; fault_clr with req=0 -> COOLDOWN, fault_code=00.
- Estop mid-PUMPING in the same cycle as a req drop -> FAULT, code 10, no rundown (valve 0 next cycle); estop during dry-run FAULT overwrites code to 10.
- ena low for 7 cycles during VALVE_OPEN -> drives and state frozen, pump start delayed by exactly 7 cycles; asynchronous rst pulse mid-PUMPING -> both drives 0 without waiting for a clock edge, cycle_count=0.
- Cooldown lockout: req toggled 0->1 during COOLDOWN -> no valve activity until IDLE, then VALVE_OPEN the next cycle.
